// File: rtl/hwacc_dispatcher_pkg.sv
// rtl/hwacc_dispatcher_pkg.sv - shared types, widths and helpers for the accelerator dispatcher
package hwacc_package;

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_HWACC_DEF = 3;
  localparam int ACC_ID_W    = clog2_min1(N_HWACC_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_CPL   = 2'd3
  } hwacc_disp_state_e;

endpackage

// File: rtl/hwacc_dispatcher_rr_arbiter.sv
// rtl/hwacc_dispatcher_rr_arbiter.sv - round-robin requester arbiter, one per accelerator
module hwacc_rr_arbiter
  import hwacc_package::*;
#(
  parameter int N_REQ = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              req_i,
  input  logic                          en_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic                          gnt_valid_o,
  output logic [clog2_min1(N_REQ)-1:0]  gnt_idx_o
);

  localparam int IDX_W = clog2_min1(N_REQ);

  logic [IDX_W-1:0] ptr_q;

  // Pick the lowest requesting index at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    if (en_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!gnt_valid_o && req_i[idx]) begin
          gnt_valid_o = 1'b1;
          gnt_o[idx]  = 1'b1;
          gnt_idx_o   = IDX_W'(idx);
        end
      end
    end
  end

  // Move the pointer just past each winner so it becomes lowest priority next time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_valid_o) begin
      ptr_q <= (int'(gnt_idx_o) == N_REQ - 1) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/hwacc_dispatcher.sv
// rtl/hwacc_dispatcher.sv - dispatches requester jobs to accelerators; watchdog under HWACC_DISPATCHER_TIMEOUT_EN
module hwacc_dispatcher
  import hwacc_package::*;
#(
  parameter int N_REQ       = 8,
  parameter int N_HWACC     = 3,
  parameter int JOB_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [N_REQ-1:0]                         req_valid_i,
  output logic [N_REQ-1:0]                         req_ready_o,
  input  logic [N_REQ*clog2_min1(N_HWACC)-1:0]     req_acc_i,
  input  logic [N_REQ*JOB_W-1:0]                   req_job_i,
  output logic [N_HWACC-1:0]                       acc_start_o,
  output logic [N_HWACC*JOB_W-1:0]                 acc_job_o,
  input  logic [N_HWACC-1:0]                       acc_done_i,
  output logic [N_HWACC-1:0]                       acc_clear_o,
  output logic [N_REQ-1:0]                         cpl_valid_o,
  output logic [N_REQ-1:0]                         cpl_err_o,
  output logic [N_HWACC-1:0]                       busy_o
);

  localparam int ID_W  = clog2_min1(N_HWACC);
  localparam int IDX_W = clog2_min1(N_REQ);

  logic [ID_W-1:0]  req_id    [N_REQ];
  logic [N_REQ-1:0] inv_gnt;
  logic [N_REQ-1:0] inv_cpl_q;
  logic [N_REQ-1:0] acc_gnt   [N_HWACC];
  logic [IDX_W-1:0] acc_owner [N_HWACC];
  logic             acc_cpl   [N_HWACC];
  logic             acc_err   [N_HWACC];

  // Unpack target IDs; out-of-range IDs are granted at once and completed with error.
  for (genvar r = 0; r < N_REQ; r++) begin : g_req
    assign req_id[r]  = req_acc_i[r*ID_W +: ID_W];
    assign inv_gnt[r] = req_valid_i[r] && (int'(req_id[r]) >= N_HWACC);
  end

  // Error completion for an invalid ID lands one cycle after its grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) inv_cpl_q <= '0;
    else       inv_cpl_q <= inv_gnt;
  end

  for (genvar a = 0; a < N_HWACC; a++) begin : g_acc
    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  gnt;
    logic              gnt_v;
    logic [IDX_W-1:0]  gnt_idx;
    hwacc_disp_state_e state_q;
    logic [JOB_W-1:0]  job_q;
    logic [IDX_W-1:0]  owner_q;
    logic              start_q;
    logic              busy_q;
    logic              cpl_q;
    logic              err_q;
`ifdef HWACC_DISPATCHER_TIMEOUT_EN
    localparam int CNT_W = clog2_min1(TIMEOUT_CYC);
    logic [CNT_W-1:0]  cnt_q;
    logic              clr_q;
`endif

    // Requesters whose target ID matches this accelerator.
    always_comb begin
      cand = '0;
      for (int r = 0; r < N_REQ; r++) begin
        cand[r] = req_valid_i[r] && (req_id[r] == ID_W'(a));
      end
    end

    hwacc_rr_arbiter #(
      .N_REQ (N_REQ)
    ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (cand),
      .en_i        (state_q == ST_IDLE),
      .gnt_o       (gnt),
      .gnt_valid_o (gnt_v),
      .gnt_idx_o   (gnt_idx)
    );

    // Job lifecycle IDLE -> START -> RUN -> CPL with registered pulses.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        job_q   <= '0;
        owner_q <= '0;
        start_q <= 1'b0;
        busy_q  <= 1'b0;
        cpl_q   <= 1'b0;
        err_q   <= 1'b0;
`ifdef HWACC_DISPATCHER_TIMEOUT_EN
        cnt_q   <= '0;
        clr_q   <= 1'b0;
`endif
      end else begin
        start_q <= 1'b0;
        cpl_q   <= 1'b0;
        err_q   <= 1'b0;
`ifdef HWACC_DISPATCHER_TIMEOUT_EN
        clr_q   <= 1'b0;
`endif
        case (state_q)
          ST_IDLE: begin
            if (gnt_v) begin
              state_q <= ST_START;
              job_q   <= req_job_i[gnt_idx*JOB_W +: JOB_W];
              owner_q <= gnt_idx;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          ST_START: begin
            state_q <= ST_RUN;
`ifdef HWACC_DISPATCHER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
          ST_RUN: begin
            if (acc_done_i[a]) begin
              state_q <= ST_CPL;
              cpl_q   <= 1'b1;
            end
`ifdef HWACC_DISPATCHER_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
              state_q <= ST_CPL;
              cpl_q   <= 1'b1;
              err_q   <= 1'b1;
              clr_q   <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
            end
`endif
          end
          ST_CPL: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end

    assign acc_gnt[a]                 = gnt;
    assign acc_owner[a]               = owner_q;
    assign acc_cpl[a]                 = cpl_q;
    assign acc_err[a]                 = err_q;
    assign acc_start_o[a]             = start_q;
    assign busy_o[a]                  = busy_q;
    assign acc_job_o[a*JOB_W +: JOB_W] = job_q;
`ifdef HWACC_DISPATCHER_TIMEOUT_EN
    assign acc_clear_o[a]             = clr_q;
`else
    assign acc_clear_o[a]             = 1'b0;
`endif
  end

  // Merge grants and route each accelerator completion back to its owner.
  always_comb begin
    logic [N_REQ-1:0] rdy;
    logic [N_REQ-1:0] cv;
    logic [N_REQ-1:0] ce;
    rdy = inv_gnt;
    cv  = inv_cpl_q;
    ce  = inv_cpl_q;
    for (int a = 0; a < N_HWACC; a++) begin
      rdy = rdy | acc_gnt[a];
      for (int r = 0; r < N_REQ; r++) begin
        if (acc_cpl[a] && (acc_owner[a] == IDX_W'(r))) begin
          cv[r] = 1'b1;
          ce[r] = ce[r] | acc_err[a];
        end
      end
    end
    req_ready_o = rst_i ? '0 : rdy;
    cpl_valid_o = rst_i ? '0 : cv;
    cpl_err_o   = rst_i ? '0 : ce;
  end

endmodule

// File: tb/tb_hwacc_dispatcher.sv
// tb/tb_hwacc_dispatcher.sv - directed scoreboard bench for hwacc_dispatcher
module tb_hwacc_dispatcher;

  localparam int N_REQ   = 8;
  localparam int N_HWACC = 3;
  localparam int JOB_W   = 32;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*ID_W-1:0]    req_acc;
  logic [N_REQ*JOB_W-1:0]   req_job;
  logic [N_HWACC-1:0]       acc_start;
  logic [N_HWACC*JOB_W-1:0] acc_job;
  logic [N_HWACC-1:0]       acc_done;
  logic [N_HWACC-1:0]       acc_clear;
  logic [N_REQ-1:0]         cpl_valid;
  logic [N_REQ-1:0]         cpl_err;
  logic [N_HWACC-1:0]       busy;

  typedef struct {
    int   req;
    logic err;
  } cpl_t;

  cpl_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hwacc_dispatcher #(
    .N_REQ       (N_REQ),
    .N_HWACC     (N_HWACC),
    .JOB_W       (JOB_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_acc_i   (req_acc),
    .req_job_i   (req_job),
    .acc_start_o (acc_start),
    .acc_job_o   (acc_job),
    .acc_done_i  (acc_done),
    .acc_clear_o (acc_clear),
    .cpl_valid_o (cpl_valid),
    .cpl_err_o   (cpl_err),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int id, input logic [31:0] job);
    req_valid[r]            = 1'b1;
    req_acc[r*ID_W +: ID_W] = id[ID_W-1:0];
    req_job[r*JOB_W +: JOB_W] = job;
  endtask

  task automatic drop_req(input int r);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_ready(input logic [N_REQ-1:0] mask, output logic [N_REQ-1:0] who);
    who = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((req_ready & mask) != '0) begin
        who = req_ready & mask;
        return;
      end
      step();
    end
  endtask

  // Every completion pulse is matched against the next expected completion.
  always @(negedge clk) begin
    cpl_t e;
    for (int r = 0; r < N_REQ; r++) begin
      if (cpl_valid[r]) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
        end else begin
          e.req = -1;
          e.err = 1'bx;
        end
        chk("sb_owner", 64'(r), 64'(e.req));
        chk("sb_err", 64'(cpl_err[r]), 64'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [N_REQ-1:0] who;
    int               fair_exp [4];
    fair_exp[0] = 2; fair_exp[1] = 5; fair_exp[2] = 7; fair_exp[3] = 2;

    rst       = 1'b1;
    req_valid = '0;
    req_acc   = '0;
    req_job   = '0;
    acc_done  = '0;
    repeat (3) step();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_start", 64'(acc_start), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cpl", 64'(cpl_valid), 64'h0);
    chk("rst_job", 64'(acc_job[63:0]), 64'h0);
    chk("rst_clear", 64'(acc_clear), 64'h0);
    rst = 1'b0;
    step();

    // single job on acc1, with a done pulse during START that must be ignored
    set_req(0, 1, 32'hCAFE0000);
    #1;
    chk("single_ready", 64'(req_ready), 64'h01);
    sb_q.push_back('{0, 1'b0});
    step();
    drop_req(0);
    acc_done[1] = 1'b1;
    #1;
    chk("single_start", 64'(acc_start), 64'h2);
    chk("single_job", 64'(acc_job[63:32]), 64'hCAFE0000);
    chk("single_busy", 64'(busy), 64'h2);
    step();
    acc_done = '0;
    #1;
    chk("single_start_once", 64'(acc_start), 64'h0);
    chk("start_done_ignored_busy", 64'(busy), 64'h2);
    chk("start_done_ignored_cpl", 64'(cpl_valid), 64'h0);
    step();
    step();
    step();
    acc_done[1] = 1'b1;
    step();
    acc_done = '0;
    #1;
    chk("single_cpl", 64'(cpl_valid), 64'h01);
    chk("single_err", 64'(cpl_err), 64'h00);
    step();
    chk("single_idle", 64'(busy), 64'h0);
    chk("single_job_held", 64'(acc_job[63:32]), 64'hCAFE0000);

    // two accelerators granted in the same cycle
    set_req(0, 0, 32'h11);
    set_req(1, 2, 32'h22);
    #1;
    chk("par_ready", 64'(req_ready), 64'h03);
    sb_q.push_back('{1, 1'b0});
    sb_q.push_back('{0, 1'b0});
    step();
    drop_req(0);
    drop_req(1);
    #1;
    chk("par_busy", 64'(busy), 64'h5);
    chk("par_start", 64'(acc_start), 64'h5);
    chk("par_job0", 64'(acc_job[31:0]), 64'h11);
    chk("par_job2", 64'(acc_job[95:64]), 64'h22);
    step();
    acc_done[2] = 1'b1;
    step();
    acc_done = '0;
    acc_done[0] = 1'b1;
    #1;
    chk("par_cpl1", 64'(cpl_valid), 64'h02);
    step();
    acc_done = '0;
    #1;
    chk("par_cpl0", 64'(cpl_valid), 64'h01);
    step();

    // out-of-range accelerator ID
    set_req(3, 3, 32'h33);
    #1;
    chk("inv_ready", 64'(req_ready), 64'h08);
    sb_q.push_back('{3, 1'b1});
    step();
    drop_req(3);
    #1;
    chk("inv_cpl", 64'(cpl_valid), 64'h08);
    chk("inv_err", 64'(cpl_err), 64'h08);
    chk("inv_busy", 64'(busy), 64'h0);
    step();
    chk("inv_cpl_once", 64'(cpl_valid), 64'h00);

    // round-robin fairness on acc0
    set_req(2, 0, 32'h102);
    set_req(5, 0, 32'h105);
    set_req(7, 0, 32'h107);
    for (int k = 0; k < 4; k++) begin
      wait_ready(8'hA4, who);
      chk("fair_winner", 64'(who), 64'(1) << fair_exp[k]);
      sb_q.push_back('{fair_exp[k], 1'b0});
      step();
      chk("fair_job", 64'(acc_job[31:0]), 64'h100 + 64'(fair_exp[k]));
      step();
      step();
      step();
      acc_done[0] = 1'b1;
      if (k == 3) begin
        drop_req(2);
        drop_req(5);
        drop_req(7);
      end
      step();
      acc_done = '0;
      step();
    end

    // reset while acc1 is running
    set_req(4, 1, 32'h44);
    #1;
    chk("rr_ready", 64'(req_ready), 64'h10);
    step();
    drop_req(4);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rr_busy", 64'(busy), 64'h0);
    chk("rr_job", 64'(acc_job[63:32]), 64'h0);
    chk("rr_cpl", 64'(cpl_valid), 64'h0);
    chk("rr_clear", 64'(acc_clear), 64'h0);
    step();
    step();
    set_req(6, 1, 32'h66);
    #1;
    chk("rr_new_ready", 64'(req_ready), 64'h40);
    sb_q.push_back('{6, 1'b0});
    step();
    drop_req(6);
    #1;
    chk("rr_new_start", 64'(acc_start), 64'h2);
    chk("rr_new_job", 64'(acc_job[63:32]), 64'h66);
    step();
    acc_done[1] = 1'b1;
    step();
    acc_done = '0;
    #1;
    chk("rr_new_cpl", 64'(cpl_valid), 64'h40);
    step();

`ifdef HWACC_DISPATCHER_TIMEOUT_EN
    // watchdog expiry without done, then done in the expiry cycle
    set_req(0, 0, 32'h77);
    #1;
    chk("to_ready", 64'(req_ready), 64'h01);
    sb_q.push_back('{0, 1'b1});
    step();
    drop_req(0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("to_no_clear", 64'(acc_clear), 64'h0);
    end
    step();
    chk("to_clear", 64'(acc_clear), 64'h1);
    chk("to_cpl", 64'(cpl_valid), 64'h01);
    chk("to_err", 64'(cpl_err), 64'h01);
    step();
    set_req(0, 0, 32'h78);
    #1;
    chk("to2_ready", 64'(req_ready), 64'h01);
    sb_q.push_back('{0, 1'b0});
    step();
    drop_req(0);
    repeat (16) step();
    acc_done[0] = 1'b1;
    step();
    acc_done = '0;
    #1;
    chk("to2_clear", 64'(acc_clear), 64'h0);
    chk("to2_cpl", 64'(cpl_valid), 64'h01);
    chk("to2_err", 64'(cpl_err), 64'h00);
    step();
`else
    // without the watchdog a job waits indefinitely and clear never pulses
    set_req(0, 0, 32'h77);
    #1;
    chk("nto_ready", 64'(req_ready), 64'h01);
    sb_q.push_back('{0, 1'b0});
    step();
    drop_req(0);
    repeat (20) step();
    chk("nto_clear", 64'(acc_clear), 64'h0);
    chk("nto_busy", 64'(busy), 64'h1);
    acc_done[0] = 1'b1;
    step();
    acc_done = '0;
    #1;
    chk("nto_cpl", 64'(cpl_valid), 64'h01);
    step();
`endif

    step();
    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
